timer555_digital: RTL and testbench
===================================

Name: timer555_digital

Overview:
- Clocked, parametrised successor to the analog 555 astable model: a digital 555-style timer with astable and monostable modes.
- Default phase lengths are computed at elaboration from R1/R2/C and the clock period using the 555 formulas.
- Phase lengths can be overridden at run time through a shadow-register load.
- Drives clock/pulse outputs to mixed-signal testbenches and digital consumers in the timer example family.

Parameters:
- R1, 100.0, real, ohms, charge resistor
- R2, 100000.0, real, ohms, discharge resistor
- C, 1e-9, real, farads, timing capacitor
- CLK_PERIOD, 1e-8, real, seconds per clk cycle
- CNT_W, 32, int, width of all count fields

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- en  input  1  run enable; low forces IDLE, like the 555 reset pin
- mode  input  1  0 = astable, 1 = monostable; sampled only in IDLE
- trig  input  1  monostable trigger; rising edge detected internally
- ld  input  1  load hi_cnt_i/lo_cnt_i into the shadow registers
- hi_cnt_i  input  CNT_W  new HIGH length (cycles); also the monostable width
- lo_cnt_i  input  CNT_W  new LOW length (cycles)
- out  output  1  timer output, registered
- dis  output  1  discharge indication, equal to ~out
- period_done  output  1  one-cycle pulse at the end of each full cycle
- cyc_cnt  output  CNT_W  completed-cycle count, wraps modulo 2^CNT_W

Behaviour:
- Elaboration-time constants (round to nearest, clamp to a minimum of 1):
  - HI_DEF = 0.693*(R1+R2)*C/CLK_PERIOD
  - LO_DEF = 0.693*R2*C/CLK_PERIOD
  - MONO_DEF = 1.1*R1*C/CLK_PERIOD
  - With the defaults: 6937, 6930, 11.
- Reset (rst=1 at a clk edge):
  - state=IDLE, out=0, dis=1, period_done=0, cyc_cnt=0, phase counter=0.
  - Shadow registers: hi_sh=HI_DEF, lo_sh=LO_DEF, mono_sh=MONO_DEF.
  - Reset mid-phase aborts immediately; no period_done pulse.
- Shadow load:
  - ld=1 writes hi_sh and mono_sh from hi_cnt_i, and lo_sh from lo_cnt_i.
  - A zero value is stored as 1.
  - Active values are latched from the shadows only on entry to HIGH or LOW. A phase already running is never resized.
- States: IDLE, HIGH, LOW. out=1 only in HIGH.
- IDLE:
  - en=1, mode=0 -> HIGH next cycle; out rises 1 cycle after en is sampled high.
  - en=1, mode=1, trig rising edge -> HIGH next cycle, length mono_sh.
- HIGH:
  - Lasts exactly N cycles: N = hi_sh (astable) or mono_sh (monostable), as latched at entry.
  - Astable: on expiry -> LOW.
  - Monostable: on expiry -> IDLE with period_done=1 and cyc_cnt+1.
- LOW (astable only):
  - Lasts exactly lo_sh cycles.
  - On expiry -> HIGH with period_done=1 and cyc_cnt+1.
  - Astable period = hi + lo cycles, with no gap cycle.
- en=0 in any state: IDLE on the next edge, out=0, no period_done.
  - en=0 wins over a simultaneous trig edge or phase expiry.
- Trig while in HIGH (monostable): ignored, non-retriggerable.
  - Trig edge detection still updates, so a trig held high does not fire again on return to IDLE.
- mode change outside IDLE: ignored until the next IDLE.
- ld coinciding with a phase entry: the entry latches the old shadow value; the new value applies at the next entry.
- cyc_cnt wraps from 2^CNT_W-1 to 0 without a flag.

Optional Feature:
- Macro: TIMER555_RETRIG_EN
- Defined:
  - A trig rising edge during monostable HIGH reloads the phase counter to mono_sh.
  - HIGH then extends to mono_sh cycles after the retrigger edge.
  - Only one period_done is produced, at final expiry.
- Undefined: retriggers are ignored as described in Behaviour.

Decomposition:
- Package timer555_pkg:
  - state enum typedef (IDLE/HIGH/LOW)
  - mode constants (MODE_ASTABLE=0, MODE_MONO=1)
  - constant function that converts a real time to a clamped cycle count (used for HI_DEF/LO_DEF/MONO_DEF)
- Sub-module timer555_phase_cnt:
  - Loadable down-counter with a load value and expiry strobe.
  - Instantiated once.
  - Supports the retrigger reload.

Test Plan:
- Astable, ld with hi=3, lo=2, then en=1 -> out pattern 1,1,1,0,0 repeating; period_done at each HIGH re-entry; cyc_cnt 1,2,3.
- Default parameters, CLK_PERIOD=1e-8 -> measured HIGH=6937 and LOW=6930 cycles; dis always equals ~out.
- Monostable with mono=11 -> trig pulse gives 11 cycles of out=1; a second trig mid-pulse is ignored; one period_done; a trig held high causes no refire.
- en dropped at cycle 2 of HIGH=5 -> out=0 next cycle, no period_done, cyc_cnt unchanged; en re-asserted -> full HIGH of 5.
- ld hi=4 during a HIGH of 3 -> current HIGH stays 3, next HIGH is 4; ld value 0 -> phase of 1 cycle; rst mid-LOW -> all outputs at reset values next cycle.
- With TIMER555_RETRIG_EN, mono=6, retrigger at cycle 4 -> out high for 10 cycles total, one period_done.

Source files
------------

// File: rtl/timer555_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer555_pkg
// Brief    : Shared types, mode encodings and the real-time to cycle helper
//            for the digital 555 timer.
// Revision : 1.0 - initial release
// ============================================================================
package timer555_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic MODE_ASTABLE = 1'b0;
    localparam logic MODE_MONO    = 1'b1;

    // Round to nearest cycle, never shorter than one cycle.
    function automatic longint cycles_of(input real t_sec, input real clk_period);
        longint n;
        n = longint'($floor(t_sec / clk_period + 0.5));
        if (n < 1) n = 1;
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer555_phase_cnt.sv
`default_nettype none
// ============================================================================
// Module   : timer555_phase_cnt
// Brief    : Loadable down-counter timing one output phase; expires at zero.
// Revision : 1.0 - initial release
// ============================================================================
module timer555_phase_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_run,
    output logic             o_expired
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/timer555_digital.sv
`default_nettype none
// ============================================================================
// Module   : timer555_digital
// Brief    : Clocked 555-style timer, astable and monostable modes, with
//            run-time phase lengths through shadow registers.
// Options  : TIMER555_RETRIG_EN - monostable pulse is retriggerable.
// Revision : 1.0 - initial release
// ============================================================================
module timer555_digital
    import timer555_pkg::*;
#(
    parameter real R1         = 100.0,
    parameter real R2         = 100000.0,
    parameter real C          = 1e-9,
    parameter real CLK_PERIOD = 1e-8,
    parameter int  CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             trig,
    input  logic             ld,
    input  logic [CNT_W-1:0] hi_cnt_i,
    input  logic [CNT_W-1:0] lo_cnt_i,
    output logic             out,
    output logic             dis,
    output logic             period_done,
    output logic [CNT_W-1:0] cyc_cnt
);

    localparam logic [CNT_W-1:0] c_HI_DEF   = CNT_W'(cycles_of(0.693 * (R1 + R2) * C, CLK_PERIOD));
    localparam logic [CNT_W-1:0] c_LO_DEF   = CNT_W'(cycles_of(0.693 * R2 * C, CLK_PERIOD));
    localparam logic [CNT_W-1:0] c_MONO_DEF = CNT_W'(cycles_of(1.1 * R1 * C, CLK_PERIOD));
    localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

    state_t           r_state;
    logic             r_mode;
    logic             r_out;
    logic             r_pdone;
    logic [CNT_W-1:0] r_cyc;
    logic             r_trig_d;
    logic [CNT_W-1:0] r_hi_sh;
    logic [CNT_W-1:0] r_lo_sh;
    logic [CNT_W-1:0] r_mono_sh;

    logic             w_trig_rise;
    logic             w_retrig;
    logic             w_expired;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;

    assign w_trig_rise = trig & ~r_trig_d;

`ifdef TIMER555_RETRIG_EN
    assign w_retrig = (r_mode == MODE_MONO) & w_trig_rise;
`else
    assign w_retrig = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_sh   <= c_HI_DEF;
            r_lo_sh   <= c_LO_DEF;
            r_mono_sh <= c_MONO_DEF;
        end else if (ld) begin
            r_hi_sh   <= (hi_cnt_i == '0) ? c_ONE : hi_cnt_i;
            r_mono_sh <= (hi_cnt_i == '0) ? c_ONE : hi_cnt_i;
            r_lo_sh   <= (lo_cnt_i == '0) ? c_ONE : lo_cnt_i;
        end
    end

    // Counter holds remaining cycles minus one, so an N-cycle phase loads N-1.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        if (en) begin
            case (r_state)
                IDLE: begin
                    if (mode == MODE_ASTABLE) begin
                        w_load     = 1'b1;
                        w_load_val = r_hi_sh - c_ONE;
                    end else if (w_trig_rise) begin
                        w_load     = 1'b1;
                        w_load_val = r_mono_sh - c_ONE;
                    end
                end
                HIGH: begin
                    if (w_retrig) begin
                        w_load     = 1'b1;
                        w_load_val = r_mono_sh - c_ONE;
                    end else if (w_expired && (r_mode == MODE_ASTABLE)) begin
                        w_load     = 1'b1;
                        w_load_val = r_lo_sh - c_ONE;
                    end
                end
                LOW: begin
                    if (w_expired) begin
                        w_load     = 1'b1;
                        w_load_val = r_hi_sh - c_ONE;
                    end
                end
                default: begin
                    w_load     = 1'b0;
                    w_load_val = '0;
                end
            endcase
        end
    end

    timer555_phase_cnt #(
        .CNT_W (CNT_W)
    ) u_phase_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_run      (r_state != IDLE),
        .o_expired  (w_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_mode   <= MODE_ASTABLE;
            r_out    <= 1'b0;
            r_pdone  <= 1'b0;
            r_cyc    <= '0;
            r_trig_d <= 1'b0;
        end else begin
            r_trig_d <= trig;
            r_pdone  <= 1'b0;
            if (!en) begin
                r_state <= IDLE;
                r_out   <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (mode == MODE_ASTABLE) begin
                            r_state <= HIGH;
                            r_mode  <= MODE_ASTABLE;
                            r_out   <= 1'b1;
                        end else if (w_trig_rise) begin
                            r_state <= HIGH;
                            r_mode  <= MODE_MONO;
                            r_out   <= 1'b1;
                        end
                    end
                    HIGH: begin
                        if (w_expired && !w_retrig) begin
                            r_out <= 1'b0;
                            if (r_mode == MODE_MONO) begin
                                r_state <= IDLE;
                                r_pdone <= 1'b1;
                                r_cyc   <= r_cyc + c_ONE;
                            end else begin
                                r_state <= LOW;
                            end
                        end
                    end
                    LOW: begin
                        if (w_expired) begin
                            r_state <= HIGH;
                            r_out   <= 1'b1;
                            r_pdone <= 1'b1;
                            r_cyc   <= r_cyc + c_ONE;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_out   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out         = r_out;
    assign dis         = ~r_out;
    assign period_done = r_pdone;
    assign cyc_cnt     = r_cyc;

endmodule
`default_nettype wire

// File: tb/tb_timer555_digital.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer555_digital
// Brief    : Self-checking bench: phase-length reference model plus directed
//            and randomized stimulus for timer555_digital.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer555_digital;

    localparam int CNT_W = 32;
`ifdef TIMER555_RETRIG_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             mode = 1'b0;
    logic             trig = 1'b0;
    logic             ld = 1'b0;
    logic [CNT_W-1:0] hi_cnt_i = '0;
    logic [CNT_W-1:0] lo_cnt_i = '0;
    logic             out;
    logic             dis;
    logic             period_done;
    logic [CNT_W-1:0] cyc_cnt;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    timer555_digital dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .mode        (mode),
        .trig        (trig),
        .ld          (ld),
        .hi_cnt_i    (hi_cnt_i),
        .lo_cnt_i    (lo_cnt_i),
        .out         (out),
        .dis         (dis),
        .period_done (period_done),
        .cyc_cnt     (cyc_cnt)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase kind, elapsed cycles in it, and its length.
    int               m_phase;    // 0 idle, 1 high, 2 low
    longint           m_len;
    longint           m_elapsed;
    longint           m_hi;
    longint           m_lo;
    longint           m_mono_len;
    bit               m_mono;
    bit               m_trig_prev;
    bit               m_rise;
    bit               m_out;
    bit               m_pd;
    logic [CNT_W-1:0] m_cyc;

    always @(posedge clk) begin
        m_rise = trig && !m_trig_prev;
        if (rst) begin
            m_phase = 0; m_out = 0; m_pd = 0; m_cyc = '0; m_trig_prev = 0;
            m_hi = 6937; m_lo = 6930; m_mono_len = 11;
            m_elapsed = 0; m_len = 0; m_mono = 0;
        end else begin
            m_trig_prev = trig;
            m_pd = 0;
            if (!en) begin
                m_phase = 0;
            end else if (m_phase == 0) begin
                if (!mode) begin
                    m_phase = 1; m_mono = 0; m_len = m_hi; m_elapsed = 0;
                end else if (m_rise) begin
                    m_phase = 1; m_mono = 1; m_len = m_mono_len; m_elapsed = 0;
                end
            end else begin
                m_elapsed++;
                if (m_phase == 1 && m_mono && RETRIG && m_rise) begin
                    m_len = m_elapsed + m_mono_len;
                end else if (m_elapsed == m_len) begin
                    if (m_phase == 1 && m_mono) begin
                        m_phase = 0; m_pd = 1; m_cyc = m_cyc + 1;
                    end else if (m_phase == 1) begin
                        m_phase = 2; m_len = m_lo; m_elapsed = 0;
                    end else begin
                        m_phase = 1; m_len = m_hi; m_elapsed = 0;
                        m_pd = 1; m_cyc = m_cyc + 1;
                    end
                end
            end
            m_out = (m_phase == 1);
            if (ld) begin
                m_hi = (hi_cnt_i == 0) ? 1 : hi_cnt_i;
                m_lo = (lo_cnt_i == 0) ? 1 : lo_cnt_i;
                m_mono_len = m_hi;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_out", out, m_out);
            check("model_dis", dis, !m_out);
            check("model_period_done", period_done, m_pd);
            check("model_cyc_cnt", cyc_cnt, m_cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; mode = 0; trig = 0; ld = 0;
        tick(2);
        rst = 0;
    endtask

    task automatic load(input int h, input int l);
        hi_cnt_i = h; lo_cnt_i = l; ld = 1;
        tick(1);
        ld = 0;
    endtask

    // Waits (bounded) for out==lvl, then counts consecutive samples at lvl.
    task automatic measure(input logic lvl, input int bound, output int n);
        int w;
        w = 0; n = 0;
        while (out !== lvl && w < bound) begin tick(1); w++; end
        while (out === lvl && n < bound) begin tick(1); n++; end
    endtask

    task automatic mono_case(input int len);
        int nh, npd;
        do_reset();
        load(len, 2);
        mode = 1; en = 1;
        tick(2);
        nh = 0; npd = 0;
        for (int i = 0; i < 40; i++) begin
            trig = (i == 0 || i == 4);
            tick(1);
            if (out) nh++;
            if (period_done) npd++;
        end
        check("mono_high_len", nh, RETRIG ? len + 4 : len);
        check("mono_pd_count", npd, 1);
        nh = 0; npd = 0;
        for (int i = 0; i < 60; i++) begin
            trig = 1;
            tick(1);
            if (out) nh++;
            if (period_done) npd++;
        end
        check("mono_held_len", nh, len);
        check("mono_held_pd", npd, 1);
        trig = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset();
        chk_on = 1;
        check("rst_out", out, 0);
        check("rst_dis", dis, 1);
        check("rst_pd", period_done, 0);
        check("rst_cyc", cyc_cnt, 0);

        // Default phase lengths from the RC parameters.
        en = 1;
        measure(1'b1, 20000, n); check("def_high", n, 6937);
        measure(1'b0, 20000, n); check("def_low", n, 6930);
        en = 0;

        // Astable 3/2 pattern.
        do_reset();
        load(3, 2);
        en = 1;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            check("ast_out", out, ((i - 1) % 5) < 3);
            if (i % 5 == 1 && i > 1) begin
                check("ast_cyc", cyc_cnt, i / 5);
                check("ast_pd", period_done, 1);
            end
        end
        en = 0;

        // en dropped in HIGH, then a full HIGH on re-enable.
        do_reset();
        load(5, 2);
        en = 1;
        tick(2);
        en = 0;
        tick(1);
        check("endrop_out", out, 0);
        check("endrop_pd", period_done, 0);
        check("endrop_cyc", cyc_cnt, 0);
        tick(2);
        en = 1;
        measure(1'b1, 20, n); check("reen_high", n, 5);
        en = 0;

        // Load during HIGH applies at the next entry; zero loads as one.
        do_reset();
        load(3, 2);
        en = 1;
        tick(1);
        load(4, 2);
        measure(1'b0, 20, n); check("ld_low", n, 2);
        measure(1'b1, 20, n); check("ld_next_high", n, 4);
        load(0, 0);
        en = 0; tick(1); en = 1;
        measure(1'b1, 20, n); check("zero_high", n, 1);
        measure(1'b0, 20, n); check("zero_low", n, 1);

        // Reset in the middle of LOW.
        load(3, 5);
        en = 0; tick(1); en = 1;
        measure(1'b1, 20, n);
        tick(1);
        rst = 1;
        tick(1);
        check("midrst_out", out, 0);
        check("midrst_dis", dis, 1);
        check("midrst_pd", period_done, 0);
        check("midrst_cyc", cyc_cnt, 0);
        rst = 0; en = 0;

        // Monostable, default width and a short width.
        mono_case(11);
        mono_case(6);

        // Randomized traffic against the model.
        do_reset();
        load(3, 2);
        for (int i = 0; i < 4000; i++) begin
            en   = ($urandom_range(0, 15) != 0);
            mode = ($urandom_range(0, 31) == 0) ? ~mode : mode;
            trig = ($urandom_range(0, 5) == 0) ? ~trig : trig;
            ld   = ($urandom_range(0, 19) == 0);
            hi_cnt_i = $urandom_range(0, 6);
            lo_cnt_i = $urandom_range(0, 6);
            rst  = ($urandom_range(0, 299) == 0);
            tick(1);
        end
        rst = 0; ld = 0;
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
